// File: rtl/fetch_controller_pkg.sv
// Shared processor definitions used by the fetch stage: machine word width,
// instruction memory depth, bubble encoding, IF/ID layout and FSM states.
package fetch_controller_pkg;

    localparam int XLEN = 32;
    localparam int DEFAULT_IMEM_WORDS = 128;
    localparam logic [XLEN-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    localparam int IFID_INSTR_WIDTH   = XLEN;
    localparam int IFID_PCPLUS4_WIDTH = XLEN;
    localparam int IFID_WIDTH         = IFID_INSTR_WIDTH + IFID_PCPLUS4_WIDTH + 1;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [IFID_INSTR_WIDTH-1:0]   instr;
        logic [IFID_PCPLUS4_WIDTH-1:0] pc_plus4;
        logic                          valid;
    } ifid_t;

    // Instruction fetches are word-granular; the two low address bits are
    // forced to zero wherever an address enters the PC.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_controller_pc_register.sv
// Program counter flop: synchronous reset to a fixed value, load when asked,
// otherwise hold.
module pc_register
    import fetch_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_value,
    output logic [XLEN-1:0] pc
);

    // PC update: reset wins, then load, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= load_value;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register and the
// RUN/HALT controller that stops fetching at the end of instruction memory.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   FETCH_RUN  | fetching: increment, redirect, stall and flush are honoured
//   FETCH_HALT | PC ran past memory; IF/ID held as a bubble until reset
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int              IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall_i,
    input  logic            Redirect_i,
    input  logic [XLEN-1:0] Target_i,
    input  logic            Flush_i,
    output logic [XLEN-1:0] IMemAddr_o,
    input  logic [XLEN-1:0] IMemData_i,
    output logic [XLEN-1:0] IFID_Instr_o,
    output logic [XLEN-1:0] IFID_PCPlus4_o,
    output logic            IFID_Valid_o,
    output logic            Halted_o,
    output logic [XLEN-1:0] FetchCount_o
);

    // One past the last legal byte address; kept one bit wider than the PC so
    // the comparison cannot wrap.
    localparam logic [XLEN:0]   PC_LIMIT       = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(4);
    localparam logic [XLEN-1:0] RESET_PC_ALIGN = word_align(RESET_PC);

    fetch_state_t    state;
    fetch_state_t    state_next;
    ifid_t           ifid_q;
    ifid_t           ifid_next;
    ifid_t           bubble;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_value;
    logic            pc_load;
    logic [XLEN:0]   pc_inc;
    logic [XLEN-1:0] target_aligned;
    logic            count_inc;
    logic [XLEN-1:0] fetch_count;

    assign pc_inc         = {1'b0, pc} + (XLEN+1)'(4);
    assign target_aligned = word_align(Target_i);
    assign bubble         = '{instr: NOP_WORD, pc_plus4: ifid_q.pc_plus4, valid: 1'b0};

    pc_register #(
        .RESET_VALUE (RESET_PC_ALIGN)
    ) u_pc_register (
        .clk        (Clk),
        .reset      (Reset),
        .load       (pc_load),
        .load_value (pc_value),
        .pc         (pc)
    );

    // State register for the RUN/HALT controller.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-PC and IF/ID selection; redirect beats stall beats
    // the sequential increment. Out-of-range PCs halt instead of wrapping.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        pc_value   = pc;
        ifid_next  = ifid_q;
        count_inc  = 1'b0;
        case (state)
            FETCH_RUN: begin
                if (Redirect_i) begin
                    ifid_next = bubble;
                    if ({1'b0, target_aligned} >= PC_LIMIT) begin
                        state_next = FETCH_HALT;
                    end else begin
                        pc_load  = 1'b1;
                        pc_value = target_aligned;
                    end
                end else if (Stall_i) begin
                    if (Flush_i) begin
                        ifid_next = bubble;
                    end
                end else begin
                    if (Flush_i) begin
                        ifid_next = bubble;
                    end else begin
                        ifid_next = '{instr: IMemData_i, pc_plus4: pc_inc[XLEN-1:0], valid: 1'b1};
                        count_inc = 1'b1;
                    end
                    if (pc_inc >= PC_LIMIT) begin
                        state_next = FETCH_HALT;
                    end else begin
                        pc_load  = 1'b1;
                        pc_value = pc_inc[XLEN-1:0];
                    end
                end
            end
            FETCH_HALT: begin
                ifid_next = bubble;
            end
            default: begin
                state_next = FETCH_RUN;
            end
        endcase
    end

    // IF/ID pipeline register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_q <= '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_next;
        end
    end

    // Saturating count of valid instructions handed to decode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count <= '0;
        end else if (count_inc && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

    assign IMemAddr_o     = pc;
    assign IFID_Instr_o   = ifid_q.instr;
    assign IFID_PCPlus4_o = ifid_q.pc_plus4;
    assign IFID_Valid_o   = ifid_q.valid;
    assign Halted_o       = (state == FETCH_HALT);
    assign FetchCount_o   = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a cycle model predicts the fetch
// stage outputs, expectations are queued as stimulus is driven and compared
// against what the DUT shows one edge later.
module tb_fetch_controller;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] LIMIT = 32'd512;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall_i;
    logic        Redirect_i;
    logic [31:0] Target_i;
    logic        Flush_i;
    logic [31:0] IMemAddr_o;
    logic [31:0] IMemData_i;
    logic [31:0] IFID_Instr_o;
    logic [31:0] IFID_PCPlus4_o;
    logic        IFID_Valid_o;
    logic        Halted_o;
    logic [31:0] FetchCount_o;

    logic [31:0] mem [0:127];

    always #5 Clk = ~Clk;

    assign IMemData_i = mem[IMemAddr_o[8:2]];

    fetch_controller dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall_i        (Stall_i),
        .Redirect_i     (Redirect_i),
        .Target_i       (Target_i),
        .Flush_i        (Flush_i),
        .IMemAddr_o     (IMemAddr_o),
        .IMemData_i     (IMemData_i),
        .IFID_Instr_o   (IFID_Instr_o),
        .IFID_PCPlus4_o (IFID_PCPlus4_o),
        .IFID_Valid_o   (IFID_Valid_o),
        .Halted_o       (Halted_o),
        .FetchCount_o   (FetchCount_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] cnt;
        logic [31:0] pc;
        logic        halted;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
    logic        m_valid, m_halt;

    // Drive one cycle of inputs, advance the model, queue the prediction and
    // record what the DUT shows just after the edge.
    task automatic cycle(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] tgt, input logic flush);
        logic [31:0] t;
        Reset = rst; Stall_i = stall; Redirect_i = redir; Target_i = tgt; Flush_i = flush;
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (redir) begin
            t = tgt & 32'hFFFF_FFFC;
            m_instr = NOP; m_valid = 1'b0;
            if (t >= LIMIT) m_halt = 1'b1;
            else m_pc = t;
        end else if (stall) begin
            if (flush) begin m_instr = NOP; m_valid = 1'b0; end
        end else begin
            if (flush) begin
                m_instr = NOP; m_valid = 1'b0;
            end else begin
                m_instr = m_pc;            // memory word i holds i*4, i.e. its own address
                m_pcp4  = m_pc + 32'd4;
                m_valid = 1'b1;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
            if (m_pc + 32'd4 >= LIMIT) m_halt = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
        exp_q.push_back(snap_t'{m_instr, m_pcp4, m_valid, m_cnt, m_pc, m_halt});
        @(posedge Clk);
        #1;
        obs_q.push_back(snap_t'{IFID_Instr_o, IFID_PCPlus4_o, IFID_Valid_o, FetchCount_o, IMemAddr_o, Halted_o});
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if ({IMemAddr_o, IFID_Instr_o, IFID_PCPlus4_o, IFID_Valid_o, FetchCount_o, Halted_o} !==
            {32'h0, NOP, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: pc=%h instr=%h pcp4=%h v=%b cnt=%0d halt=%b, expected all zero",
                     IMemAddr_o, IFID_Instr_o, IFID_PCPlus4_o, IFID_Valid_o, FetchCount_o, Halted_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_sequential();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (IFID_Instr_o !== 32'(i*4) || IFID_PCPlus4_o !== 32'(i*4+4) || IFID_Valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: instr=%h pcp4=%h v=%b, expected instr=%h pcp4=%h v=1",
                         i, IFID_Instr_o, IFID_PCPlus4_o, IFID_Valid_o, i*4, i*4+4);
            end
        end
        n_checks++;
        if (FetchCount_o !== 32'd4) begin
            n_fail++; $display("FAIL seq_count: got %0d expected 4", FetchCount_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL seq_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_stall();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        free_run(2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (IMemAddr_o !== 32'd8 || IFID_Instr_o !== 32'd4 || IFID_Valid_o !== 1'b1 || FetchCount_o !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h v=%b cnt=%0d, expected pc=8 instr=4 v=1 cnt=2",
                         i, IMemAddr_o, IFID_Instr_o, IFID_Valid_o, FetchCount_o);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (IFID_Instr_o !== 32'd8 || IFID_PCPlus4_o !== 32'd12 || FetchCount_o !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_release: instr=%h pcp4=%h cnt=%0d, expected instr=8 pcp4=c cnt=3",
                     IFID_Instr_o, IFID_PCPlus4_o, FetchCount_o);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (IFID_Valid_o !== 1'b0 || IFID_Instr_o !== NOP || IMemAddr_o !== 32'd12 || FetchCount_o !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_flush: v=%b instr=%h pc=%h cnt=%0d, expected v=0 instr=NOP pc=c cnt=3",
                     IFID_Valid_o, IFID_Instr_o, IMemAddr_o, FetchCount_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL stall_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_redirect_stall();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        free_run(1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_002E, 1'b0);
        n_checks++;
        if (IMemAddr_o !== 32'h2C || IFID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_pc: pc=%h v=%b, expected pc=2c v=0", IMemAddr_o, IFID_Valid_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (IFID_Instr_o !== 32'd44 || IFID_PCPlus4_o !== 32'd48 || IFID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_fetch: instr=%h pcp4=%h v=%b, expected instr=2c pcp4=30 v=1",
                     IFID_Instr_o, IFID_PCPlus4_o, IFID_Valid_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL redirect_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_flush();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        free_run(4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (IFID_Valid_o !== 1'b0 || IFID_Instr_o !== NOP || IMemAddr_o !== 32'd20 || FetchCount_o !== 32'd4) begin
            n_fail++;
            $display("FAIL flush: v=%b instr=%h pc=%h cnt=%0d, expected v=0 instr=NOP pc=14 cnt=4",
                     IFID_Valid_o, IFID_Instr_o, IMemAddr_o, FetchCount_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL flush_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_runoff();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        free_run(127);
        n_checks++;
        if (IMemAddr_o !== 32'd508 || FetchCount_o !== 32'd127) begin
            n_fail++; $display("FAIL runoff_reach: pc=%h cnt=%0d, expected pc=1fc cnt=127", IMemAddr_o, FetchCount_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (IFID_Instr_o !== 32'd508 || IFID_Valid_o !== 1'b1 || IMemAddr_o !== 32'd508 || FetchCount_o !== 32'd128) begin
            n_fail++;
            $display("FAIL runoff_last: instr=%h v=%b pc=%h cnt=%0d, expected instr=1fc v=1 pc=1fc cnt=128",
                     IFID_Instr_o, IFID_Valid_o, IMemAddr_o, FetchCount_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (Halted_o !== 1'b1 || IFID_Valid_o !== 1'b0 || IMemAddr_o !== 32'd508) begin
            n_fail++;
            $display("FAIL runoff_halt: halt=%b v=%b pc=%h, expected halt=1 v=0 pc=1fc", Halted_o, IFID_Valid_o, IMemAddr_o);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
        n_checks++;
        if (Halted_o !== 1'b1 || IMemAddr_o !== 32'd508) begin
            n_fail++; $display("FAIL halt_ignore_redirect: halt=%b pc=%h, expected halt=1 pc=1fc", Halted_o, IMemAddr_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL runoff_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_halt_exit();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        free_run(2);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        n_checks++;
        if (Halted_o !== 1'b1 || IMemAddr_o !== 32'h48 || IFID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_halt: halt=%b pc=%h v=%b, expected halt=1 pc=48 v=0", Halted_o, IMemAddr_o, IFID_Valid_o);
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b1);
        n_checks++;
        if (Halted_o !== 1'b0 || IMemAddr_o !== 32'h0 || FetchCount_o !== 32'd0 || IFID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: halt=%b pc=%h cnt=%0d v=%b, expected all zero",
                     Halted_o, IMemAddr_o, FetchCount_o, IFID_Valid_o);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL halt_sb: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_random();
        snap_t e, o;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 3,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  32'($urandom_range(0, 560)),
                  $urandom_range(0, 5) == 0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random_sb: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
        Reset = 1'b1; Stall_i = 1'b0; Redirect_i = 1'b0; Target_i = 32'h0; Flush_i = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_halt = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_flush();
        test_runoff();
        test_halt_exit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
